// File: rtl/mem_bus_ctrl.sv
// CPU-to-memory-map bus controller: ROM, synchronous RW and I/O ports behind one 8-bit req/ack bus.
// Latency: ack is high 3 cycles after req is sampled; back-to-back requests complete every 4 cycles.
// Backpressure: one request in flight, cpu_req is ignored until IDLE. `BUS_FAULT_EN adds sticky bus_fault.
module mem_bus_ctrl #(
    parameter int RW_LO    = 128,
    parameter int RW_HI    = 223,
    parameter int OUT_BASE = 224,
    parameter int IN_BASE  = 240
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic [7:0] cpu_rdata,
    output logic       cpu_ack,
    output logic [7:0] mem_address,
    output logic [7:0] mem_data_in,
    output logic       mem_we,
    input  logic [7:0] rom_data,
    input  logic [7:0] rw_data,
    input  logic [7:0] port_in_00,
    input  logic [7:0] port_in_01,
    input  logic [7:0] port_in_02,
    input  logic [7:0] port_in_03,
`ifdef BUS_FAULT_EN
    output logic       bus_fault,
`endif
    output logic [7:0] port_out_00,
    output logic [7:0] port_out_01,
    output logic [7:0] port_out_02,
    output logic [7:0] port_out_03
);

    localparam logic [8:0] RW_LO_W  = 9'(RW_LO);
    localparam logic [8:0] RW_HI_W  = 9'(RW_HI);
    localparam logic [8:0] OUT_LO_W = 9'(OUT_BASE);
    localparam logic [8:0] OUT_HI_W = 9'(OUT_BASE + 3);
    localparam logic [8:0] IN_LO_W  = 9'(IN_BASE);
    localparam logic [8:0] IN_HI_W  = 9'(IN_BASE + 3);
    localparam logic [7:0] OUT_B8   = 8'(OUT_BASE);
    localparam logic [7:0] IN_B8    = 8'(IN_BASE);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, ACK} state_t;

    state_t          state;
    logic [7:0]      req_addr;
    logic [7:0]      req_wdata;
    logic            req_we;
    logic [3:0][7:0] pout;
    logic [3:0][7:0] pin;
    logic            is_rom, is_rw, is_out, is_in;
    logic [1:0]      out_idx, in_idx;
    logic [7:0]      rd_mux;

    // Decode widened to 9 bits so range bounds at 255 never wrap.
    function automatic logic in_range(input logic [7:0] a, input logic [8:0] lo, input logic [8:0] hi);
        return ({1'b0, a} >= lo) && ({1'b0, a} <= hi);
    endfunction

    assign is_rom  = {1'b0, req_addr} < RW_LO_W;
    assign is_rw   = in_range(req_addr, RW_LO_W, RW_HI_W);
    assign is_out  = in_range(req_addr, OUT_LO_W, OUT_HI_W);
    assign is_in   = in_range(req_addr, IN_LO_W, IN_HI_W);
    assign out_idx = 2'(req_addr - OUT_B8);
    assign in_idx  = 2'(req_addr - IN_B8);

    assign pin         = {port_in_03, port_in_02, port_in_01, port_in_00};
    assign port_out_00 = pout[0];
    assign port_out_01 = pout[1];
    assign port_out_02 = pout[2];
    assign port_out_03 = pout[3];

    always_comb begin
        rd_mux = 8'h00;
        if (is_rom)      rd_mux = rom_data;
        else if (is_rw)  rd_mux = rw_data;
        else if (is_out) rd_mux = pout[out_idx];
        else if (is_in)  rd_mux = pin[in_idx];
    end

`ifdef BUS_FAULT_EN
    logic fault_hit;
    assign fault_hit = !(is_rom || is_rw || is_out || is_in) || (req_we && is_rom);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            req_addr    <= 8'h00;
            req_wdata   <= 8'h00;
            req_we      <= 1'b0;
            cpu_rdata   <= 8'h00;
            cpu_ack     <= 1'b0;
            mem_address <= 8'h00;
            mem_data_in <= 8'h00;
            mem_we      <= 1'b0;
            pout        <= '0;
`ifdef BUS_FAULT_EN
            bus_fault   <= 1'b0;
`endif
        end else begin
            cpu_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        req_addr    <= cpu_addr;
                        req_we      <= cpu_we;
                        req_wdata   <= cpu_wdata;
                        mem_address <= cpu_addr;
                        mem_data_in <= cpu_wdata;
                        mem_we      <= cpu_we && in_range(cpu_addr, RW_LO_W, RW_HI_W);
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    // RW samples address/we on this edge, so write enable lasts exactly one cycle.
                    mem_we <= 1'b0;
                    if (req_we && is_out) pout[out_idx] <= req_wdata;
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    if (!req_we) cpu_rdata <= rd_mux;
                    cpu_ack <= 1'b1;
`ifdef BUS_FAULT_EN
                    if (fault_hit) bus_fault <= 1'b1;
`endif
                    state <= ACK;
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Randomized bench for mem_bus_ctrl with a ROM/RW memory environment and an address-map reference model.
module tb_mem_bus_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_req, cpu_we;
    logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic       cpu_ack;
    logic [7:0] mem_address, mem_data_in;
    logic       mem_we;
    logic [7:0] rom_data, rw_data;
    logic [7:0] port_in_00, port_in_01, port_in_02, port_in_03;
    logic [7:0] port_out_00, port_out_01, port_out_02, port_out_03;
`ifdef BUS_FAULT_EN
    logic       bus_fault;
`endif

    always #5 clk = ~clk;

    mem_bus_ctrl dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_we(mem_we),
        .rom_data(rom_data), .rw_data(rw_data),
        .port_in_00(port_in_00), .port_in_01(port_in_01), .port_in_02(port_in_02), .port_in_03(port_in_03),
`ifdef BUS_FAULT_EN
        .bus_fault(bus_fault),
`endif
        .port_out_00(port_out_00), .port_out_01(port_out_01), .port_out_02(port_out_02), .port_out_03(port_out_03)
    );

    // ROM contents; address 5 holds 0xC3.
    function automatic logic [7:0] rom_val(input logic [6:0] a);
        if (a == 7'd5) return 8'hC3;
        return 8'(int'(a) * 37 + 11);
    endfunction

    // Memory environment: synchronous ROM and RW, one cycle read latency.
    logic [7:0] rw_mem [256];
    logic       mem_init;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) rw_mem[i] <= 8'(i * 7 + 3);
        end else if (mem_we) begin
            rw_mem[mem_address] <= mem_data_in;
        end
        rw_data  <= rw_mem[mem_address];
        rom_data <= rom_val(mem_address[6:0]);
    end

    logic [7:0] pin [4];
    assign port_in_00 = pin[0];
    assign port_in_01 = pin[1];
    assign port_in_02 = pin[2];
    assign port_in_03 = pin[3];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    logic [7:0] ref_rw [256];
    logic [7:0] ref_out [4];
    logic [7:0] exp_rdata;
    bit         ref_fault;
    bit         last_hold;
    int         last_ack;
    int         n_vec = 0;
    int         n_miss = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_read(input logic [7:0] a);
        int ai;
        ai = int'(a);
        if (ai < 128) return rom_val(a[6:0]);
        if (ai <= 223) return ref_rw[ai];
        if (ai <= 227) return ref_out[ai - 224];
        if (ai >= 240 && ai <= 243) return pin[ai - 240];
        return 8'h00;
    endfunction

    function automatic logic [31:0] pouts();
        return {port_out_03, port_out_02, port_out_01, port_out_00};
    endfunction

    function automatic logic [31:0] ref_pouts();
        return {ref_out[3], ref_out[2], ref_out[1], ref_out[0]};
    endfunction

    // One request; hold leaves cpu_req high so the next call launches back-to-back.
    task automatic txn(input bit we, input logic [7:0] a, input logic [7:0] wd, input bit hold);
        int ai;
        int k;
        bit exp_we;
        ai = int'(a);
        exp_we = we && ai >= 128 && ai <= 223;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        @(posedge clk);
        #1 cpu_req = hold;
        @(negedge clk);
        check_eq("issue_addr", 32'(mem_address), 32'(a));
        check_eq("issue_wdata", 32'(mem_data_in), 32'(wd));
        check_eq("issue_we", 32'(mem_we), 32'(exp_we));
        check_eq("issue_ack", 32'(cpu_ack), 0);
        check_eq("issue_pout", pouts(), ref_pouts());
        // Activity while busy must be ignored.
        cpu_req = !cpu_req; cpu_we = 1'($urandom); cpu_addr = 8'($urandom); cpu_wdata = 8'($urandom);
        if (exp_we) ref_rw[ai] = wd;
        if (we && ai >= 224 && ai <= 227) ref_out[ai - 224] = wd;
        if (!we) exp_rdata = ref_read(a);
        if ((ai >= 228 && ai <= 239) || ai >= 244 || (we && ai < 128)) ref_fault = 1'b1;
        @(negedge clk);
        check_eq("capt_we", 32'(mem_we), 0);
        check_eq("capt_ack", 32'(cpu_ack), 0);
        check_eq("capt_pout", pouts(), ref_pouts());
        cpu_req = hold;
        @(negedge clk);
        k = 3;
        while (!cpu_ack && k < 10) begin
            @(negedge clk);
            k++;
        end
        check_eq("ack_lat", 32'(k), 3);
        check_eq("rdata", 32'(cpu_rdata), 32'(exp_rdata));
        check_eq("ack_we", 32'(mem_we), 0);
`ifdef BUS_FAULT_EN
        check_eq("bus_fault", 32'(bus_fault), 32'(ref_fault));
`endif
        if (last_hold) check_eq("b2b_gap", 32'(cyc - last_ack), 4);
        last_ack  = cyc;
        last_hold = hold;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; mem_init = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
        for (int i = 0; i < 4; i++) begin pin[i] = 8'($urandom); ref_out[i] = 8'h00; end
        for (int i = 0; i < 256; i++) ref_rw[i] = 8'(i * 7 + 3);
        exp_rdata = 8'h00; ref_fault = 1'b0; last_hold = 1'b0; last_ack = 0;
        repeat (3) @(negedge clk);
        mem_init = 1'b0;
        check_eq("rst_ack", 32'(cpu_ack), 0);
        check_eq("rst_rdata", 32'(cpu_rdata), 0);
        check_eq("rst_maddr", 32'(mem_address), 0);
        check_eq("rst_mdata", 32'(mem_data_in), 0);
        check_eq("rst_mwe", 32'(mem_we), 0);
        check_eq("rst_pout", pouts(), 0);
`ifdef BUS_FAULT_EN
        check_eq("rst_fault", 32'(bus_fault), 0);
`endif
        reset = 1'b1;

        // Directed scenarios
        txn(1'b1, 8'd130, 8'h5A, 1'b0);
        txn(1'b0, 8'd130, 8'h00, 1'b0);
        txn(1'b0, 8'd5,   8'h00, 1'b0);
        txn(1'b1, 8'd225, 8'h77, 1'b0);
        txn(1'b0, 8'd225, 8'h00, 1'b0);
        pin[2] = 8'h9E;
        txn(1'b0, 8'd242, 8'h00, 1'b0);
        txn(1'b1, 8'd10,  8'h11, 1'b0);
        txn(1'b0, 8'd230, 8'h00, 1'b0);
        txn(1'b0, 8'd0,   8'h00, 1'b0);
        txn(1'b0, 8'd255, 8'h00, 1'b0);
        txn(1'b0, 8'd128, 8'h00, 1'b1);
        txn(1'b0, 8'd129, 8'h00, 1'b1);
        txn(1'b0, 8'd223, 8'h00, 1'b0);

        // Randomized traffic over the full map
        for (int n = 0; n < 150; n++) begin
            for (int i = 0; i < 4; i++) pin[i] = 8'($urandom);
            txn(1'($urandom), 8'($urandom_range(0, 255)), 8'($urandom), ($urandom_range(0, 3) == 0));
        end

        // Reset during CAPTURE of a read after port_out_00 is loaded
        txn(1'b1, 8'd224, 8'hFF, 1'b0);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'd224;
        @(posedge clk);
        #1 cpu_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("mid_rst_ack", 32'(cpu_ack), 0);
        check_eq("mid_rst_rdata", 32'(cpu_rdata), 0);
        check_eq("mid_rst_maddr", 32'(mem_address), 0);
        check_eq("mid_rst_mdata", 32'(mem_data_in), 0);
        check_eq("mid_rst_mwe", 32'(mem_we), 0);
        check_eq("mid_rst_pout", pouts(), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("mid_rst_noack", 32'(cpu_ack), 0);
        end
        reset = 1'b1;
        for (int i = 0; i < 4; i++) ref_out[i] = 8'h00;
        exp_rdata = 8'h00; ref_fault = 1'b0; last_hold = 1'b0;
        txn(1'b0, 8'd224, 8'h00, 1'b0);
        txn(1'b0, 8'd140, 8'h00, 1'b0);

        cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
